// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage: access sizes, the
// MEM-stage FSM state type and address-lane helpers.
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is reserved and behaves as word

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_t;

  // Byte lane actually used on the bus once the low address bits are forced
  // onto the natural boundary of the access size.
  function automatic logic [1:0] lane_align(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: lane_align = a;
      SIZE_HALF: lane_align = {a[1], 1'b0};
      default:   lane_align = 2'b00;
    endcase
  endfunction

  // True when the access does not sit on its natural boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = a[0];
      default:   misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load/store lane logic for the MEM stage (purely combinational).
// Store side: byte enables and lane-replicated write data from the current
// request. Load side: lane select and sign/zero extension of the returned word
// using the attributes captured when the access was launched.
module lsu_align
  import mips_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_lane_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lane_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store: byte enables follow the lane, data is replicated so any lane sees it.
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      SIZE_BYTE: begin
        st_be_o    = 4'b0001 << st_lane_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SIZE_HALF: begin
        st_be_o    = st_lane_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load: pick the addressed lane, then extend to 32 bits.
  always_comb begin
    ld_byte = ld_rdata_i[7:0];
    case (ld_lane_i)
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      2'd3:    ld_byte = ld_rdata_i[31:24];
      default: ;
    endcase
    ld_half = ld_lane_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_size_i)
      SIZE_BYTE: ld_data_o = ld_unsigned_i ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data_o = ld_unsigned_i ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:   ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Launches loads/stores on a req/ack
// data bus with variable wait states, stalls IF..EX while an access is in
// flight, aborts accesses that are never acked (watchdog), and registers the
// MEM/WB latch.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses are
// refused (o_misalign pulse) instead of being forced onto alignment.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pcplus4,
  input  logic [31:0] i_result,
  input  logic [31:0] i_dato2,
  input  logic [4:0]  i_writeRegister,
  input  logic        i_memToReg,
  input  logic        i_regWrite,
  input  logic        i_memWrite,
  input  logic        i_memRead,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic [31:0] o_pcplus4,
  output logic [31:0] o_result,
  output logic [31:0] o_readData,
  output logic [4:0]  o_writeRegister,
  output logic        o_memToReg,
  output logic        o_regWrite,
`ifdef MISALIGN_TRAP_EN
  output logic        o_misalign,
`endif
  output logic        o_bus_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  mem_state_t      state_q, state_d;
  logic [TO_W-1:0] wd_q, wd_d;

  // bus request registers
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  // fields captured at launch, released into MEM/WB on ack
  logic [31:0] cap_pc_q, cap_res_q;
  logic [4:0]  cap_rd_q;
  logic        cap_m2r_q, cap_rw_q, cap_uns_q;
  logic [1:0]  cap_size_q, cap_lane_q;

  // MEM/WB latch
  logic [31:0] wb_pc_q, wb_res_q, wb_rdata_q;
  logic [4:0]  wb_rd_q;
  logic        wb_m2r_q, wb_rw_q, bus_err_q;

  logic        access, launch, trap, done, abort, stall;
  logic [1:0]  lane_in;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  assign access  = i_memRead | i_memWrite;
  assign lane_in = lane_align(i_size, i_result[1:0]);
`ifdef MISALIGN_TRAP_EN
  assign trap    = access & misaligned(i_size, i_result[1:0]);
  logic misalign_q;
  assign o_misalign = misalign_q;
`else
  assign trap    = 1'b0;
`endif

  lsu_align u_align (
    .st_size_i    (i_size),
    .st_lane_i    (lane_in),
    .st_data_i    (i_dato2),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_size_i    (cap_size_q),
    .ld_lane_i    (cap_lane_q),
    .ld_unsigned_i(cap_uns_q),
    .ld_rdata_i   (i_dmem_rdata),
    .ld_data_o    (ld_data)
  );

  // FSM next state, watchdog and stall; ack in the timeout cycle completes normally.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    stall   = 1'b0;
    launch  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (access && !trap) begin
        stall   = 1'b1;
        launch  = 1'b1;
        wd_d    = '0;
        state_d = BUSY;
      end
      BUSY: if (i_dmem_ack) begin
        done    = 1'b1;
        state_d = IDLE;
      end else if (wd_q == TO_LAST) begin
        abort   = 1'b1;
        state_d = IDLE;
      end else begin
        stall   = 1'b1;
        wd_d    = wd_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces every output low, the stall included.
  assign o_stall = stall & ~rst;

  // State register and watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Bus request registers and launch-time capture; bus is parked at zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cap_pc_q   <= '0;
      cap_res_q  <= '0;
      cap_rd_q   <= '0;
      cap_m2r_q  <= 1'b0;
      cap_rw_q   <= 1'b0;
      cap_uns_q  <= 1'b0;
      cap_size_q <= '0;
      cap_lane_q <= '0;
    end else if (launch) begin
      req_q      <= 1'b1;
      we_q       <= i_memWrite;
      addr_q     <= {i_result[31:2], 2'b00};
      wdata_q    <= i_memWrite ? st_wdata : 32'd0;
      be_q       <= st_be;
      cap_pc_q   <= i_pcplus4;
      cap_res_q  <= i_result;
      cap_rd_q   <= i_writeRegister;
      cap_m2r_q  <= i_memToReg;
      cap_rw_q   <= i_regWrite;
      cap_uns_q  <= i_unsigned;
      cap_size_q <= i_size;
      cap_lane_q <= lane_in;
    end else if (done || abort) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end
  end

  // MEM/WB latch: pass-through for ALU ops, captured fields on ack, bubble otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_pc_q    <= '0;
      wb_res_q   <= '0;
      wb_rdata_q <= '0;
      wb_rd_q    <= '0;
      wb_m2r_q   <= 1'b0;
      wb_rw_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= abort;
      if (done) begin
        wb_pc_q    <= cap_pc_q;
        wb_res_q   <= cap_res_q;
        wb_rdata_q <= we_q ? 32'd0 : ld_data;
        wb_rd_q    <= cap_rd_q;
        wb_m2r_q   <= cap_m2r_q;
        wb_rw_q    <= cap_rw_q;
      end else if (state_q == IDLE && !access) begin
        wb_pc_q    <= i_pcplus4;
        wb_res_q   <= i_result;
        wb_rdata_q <= '0;
        wb_rd_q    <= i_writeRegister;
        wb_m2r_q   <= i_memToReg;
        wb_rw_q    <= i_regWrite;
      end else begin
        wb_pc_q    <= '0;
        wb_res_q   <= '0;
        wb_rdata_q <= '0;
        wb_rd_q    <= '0;
        wb_m2r_q   <= 1'b0;
        wb_rw_q    <= 1'b0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle flag for a refused misaligned access.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= (state_q == IDLE) && trap;
  end
`endif

  assign o_dmem_req      = req_q;
  assign o_dmem_we       = we_q;
  assign o_dmem_addr     = addr_q;
  assign o_dmem_wdata    = wdata_q;
  assign o_dmem_be       = be_q;
  assign o_pcplus4       = wb_pc_q;
  assign o_result        = wb_res_q;
  assign o_readData      = wb_rdata_q;
  assign o_writeRegister = wb_rd_q;
  assign o_memToReg      = wb_m2r_q;
  assign o_regWrite      = wb_rw_q;
  assign o_bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage. Each transaction task knows its own
// timeline (launch, wait states, ack or abort) and sets the expected outputs
// cycle by cycle; one compare process checks every output on the falling edge.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_pcplus4, i_result, i_dato2, i_dmem_rdata;
  logic [4:0]  i_writeRegister;
  logic        i_memToReg, i_regWrite, i_memWrite, i_memRead, i_unsigned, i_dmem_ack;
  logic [1:0]  i_size;
  logic        o_dmem_req, o_dmem_we, o_stall, o_memToReg, o_regWrite, o_bus_err;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_pcplus4, o_result, o_readData;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_writeRegister;
  logic        o_misalign;

  typedef struct {
    logic        req, we, stall, m2r, rw, err, mis;
    logic [31:0] addr, wdata, pc, res, rdata;
    logic [3:0]  be;
    logic [4:0]  rd;
  } obs_t;

  obs_t cur, nxt, zero_obs;
  int   checks = 0, fails = 0, stall_seen = 0;
  bit   chk_en = 0;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;

  always #5 clk = ~clk;

  mem_access_stage #(.ACK_TIMEOUT(TO), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_pcplus4(i_pcplus4), .i_result(i_result), .i_dato2(i_dato2),
    .i_writeRegister(i_writeRegister), .i_memToReg(i_memToReg), .i_regWrite(i_regWrite),
    .i_memWrite(i_memWrite), .i_memRead(i_memRead), .i_size(i_size), .i_unsigned(i_unsigned),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_pcplus4(o_pcplus4), .o_result(o_result), .o_readData(o_readData),
    .o_writeRegister(o_writeRegister), .o_memToReg(o_memToReg), .o_regWrite(o_regWrite),
`ifdef MISALIGN_TRAP_EN
    .o_misalign(o_misalign),
`endif
    .o_bus_err(o_bus_err)
  );

`ifndef MISALIGN_TRAP_EN
  assign o_misalign = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- reference arithmetic, straight from the bus/lane rules ----
  function automatic logic [1:0] m_lane(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'b00) return a;
    if (sz == 2'b01) return a & 2'b10;
    return 2'b00;
  endfunction

  function automatic int m_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    int n = m_bytes(sz);
    logic [3:0] ones = 4'((1 << n) - 1);
    return ones << m_lane(sz, a);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return {24'd0, d[7:0]} * 32'h01010101;
    if (sz == 2'b01) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic un,
                                         input logic [1:0] a, input logic [31:0] rd);
    int n = m_bytes(sz);
    logic [31:0] mask, v;
    if (n == 4) return rd;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rd >> (8 * m_lane(sz, a))) & mask;
    if (!un && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- compare process ----
  always @(negedge clk) begin
    if (chk_en) begin
      if (o_stall === 1'b1) stall_seen++;
      chk("dmem_req", o_dmem_req, cur.req);
      chk("dmem_we", o_dmem_we, cur.we);
      chk("dmem_addr", o_dmem_addr, cur.addr);
      chk("dmem_wdata", o_dmem_wdata, cur.wdata);
      chk("dmem_be", o_dmem_be, cur.be);
      chk("stall", o_stall, cur.stall);
      chk("wb_pcplus4", o_pcplus4, cur.pc);
      chk("wb_result", o_result, cur.res);
      chk("wb_readData", o_readData, cur.rdata);
      chk("wb_writeReg", o_writeRegister, cur.rd);
      chk("wb_memToReg", o_memToReg, cur.m2r);
      chk("wb_regWrite", o_regWrite, cur.rw);
      chk("bus_err", o_bus_err, cur.err);
`ifdef MISALIGN_TRAP_EN
      chk("misalign", o_misalign, cur.mis);
`endif
    end
  end

  // Advance one clock; expectations prepared for this edge become current.
  task automatic tick();
    @(posedge clk);
    #1;
    cur = nxt;
    cur.stall = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, res, d2, input logic [4:0] rd,
                       input logic m2r, rw, mw, mr, input logic [1:0] sz, input logic un);
    i_pcplus4 = pc; i_result = res; i_dato2 = d2; i_writeRegister = rd;
    i_memToReg = m2r; i_regWrite = rw; i_memWrite = mw; i_memRead = mr;
    i_size = sz; i_unsigned = un;
  endtask

  // Non-memory instruction: one-cycle pass-through into MEM/WB.
  task automatic alu(input logic [31:0] pc, res, input logic [4:0] rd, input logic m2r, rw);
    drive(pc, res, 32'h0, rd, m2r, rw, 1'b0, 1'b0, 2'b10, 1'b0);
    cur.stall = 1'b0;
    nxt = zero_obs;
    nxt.pc = pc; nxt.res = res; nxt.rd = rd; nxt.m2r = m2r; nxt.rw = rw;
    tick();
  endtask

  // Load/store with 'waits' ack-less BUSY cycles before the ack; waits >= TO never acks.
  task automatic access(input logic [31:0] pc, res, d2, input logic [4:0] rd,
                        input logic m2r, rw, mw, mr, input logic [1:0] sz, input logic un,
                        input int waits, input logic [31:0] rdata);
    obs_t busy;
    drive(pc, res, d2, rd, m2r, rw, mw, mr, sz, un);
    cur.stall = 1'b1;
    busy = zero_obs;
    busy.req = 1'b1; busy.we = mw;
    busy.addr = {res[31:2], 2'b00};
    busy.be = m_be(sz, res[1:0]);
    busy.wdata = mw ? m_wdata(sz, d2) : 32'd0;
    nxt = busy;
    tick();
    snap_addr = o_dmem_addr; snap_wdata = o_dmem_wdata; snap_be = o_dmem_be;
    for (int w = 0; w < TO; w++) begin
      if (w == waits) begin
        i_dmem_ack = 1'b1; i_dmem_rdata = rdata;
        cur.stall = 1'b0;
        nxt = zero_obs;
        nxt.pc = pc; nxt.res = res; nxt.rd = rd; nxt.m2r = m2r; nxt.rw = rw;
        nxt.rdata = mw ? 32'd0 : m_load(sz, un, res[1:0], rdata);
        tick();
        i_dmem_ack = 1'b0;
        break;
      end else if (w == TO - 1) begin
        cur.stall = 1'b0;
        nxt = zero_obs;
        nxt.err = 1'b1;
        tick();
      end else begin
        cur.stall = 1'b1;
        nxt = busy;
        tick();
      end
    end
  endtask

  int s0;

  initial begin
    zero_obs = '{default: '0};
    cur = zero_obs; nxt = zero_obs;
    rst = 1'b1; i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick(); tick();
    chk_en = 1'b1;
    // reset held with a load presented: no stall, everything stays 0
    drive(32'h4, 32'h100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    cur.stall = 1'b0; nxt = zero_obs;
    tick();
    rst = 1'b0;

    // ALU op: one-cycle pass-through
    alu(32'h0000_0104, 32'h0000_1234, 5'd5, 1'b0, 1'b1);
    chk("alu_result_lit", o_result, 32'h0000_1234);
    chk("alu_regwrite_lit", o_regWrite, 32'd1);
    chk("alu_rd_lit", o_writeRegister, 32'd5);

    // LB 0x103 signed, 3 wait states: ack lands in the watchdog's last cycle and wins
    s0 = stall_seen;
    access(32'h108, 32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 3, 32'h80FF_FFFF);
    chk("lb_readdata_lit", o_readData, 32'hFFFF_FF80);
    chk("lb_bus_err_lit", o_bus_err, 32'd0);
    alu(32'h10C, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("lb_stall_cycles", stall_seen - s0, 32'd4);

    // LHU 0x102, ack in the first BUSY cycle -> 2-cycle latency
    s0 = stall_seen;
    access(32'h110, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 0, 32'hBEEF_0000);
    chk("lhu_readdata_lit", o_readData, 32'h0000_BEEF);
    alu(32'h114, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("lhu_stall_cycles", stall_seen - s0, 32'd1);

    // SB 0x201 data 0xAB
    access(32'h118, 32'h201, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1, 32'h0);
    chk("sb_be_lit", snap_be, 32'b0010);
    chk("sb_wdata_lit", snap_wdata, 32'hABAB_ABAB);
    chk("sb_addr_lit", snap_addr, 32'h0000_0200);
    chk("sb_regwrite_lit", o_regWrite, 32'd0);

    // read+write together: store only; back-to-back with the next access
    access(32'h11C, 32'h300, 32'h1122_3344, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2, 32'hFFFF_FFFF);
    chk("sw_rw_readdata_lit", o_readData, 32'd0);
    access(32'h120, 32'h202, 32'h0000_CAFE, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 0, 32'h0);
    chk("sh_be_lit", snap_be, 32'b1100);
    chk("sh_wdata_lit", snap_wdata, 32'hCAFE_CAFE);
    access(32'h124, 32'h100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1, 32'h0000_8001);
    chk("lh_readdata_lit", o_readData, 32'hFFFF_8001);
    access(32'h128, 32'h101, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 0, 32'h0000_F000);
    access(32'h12C, 32'h500, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 2, 32'h0BAD_F00D);

    // ack while idle is ignored
    alu(32'h130, 32'h77, 5'd1, 1'b0, 1'b1);
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
    alu(32'h134, 32'h78, 5'd2, 1'b0, 1'b1);
    i_dmem_ack = 1'b0;

    // watchdog: never acked -> abort after TO BUSY cycles
    access(32'h138, 32'h400, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 99, 32'h0);
    chk("to_bus_err_lit", o_bus_err, 32'd1);
    chk("to_req_drop_lit", o_dmem_req, 32'd0);
    alu(32'h13C, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("to_err_pulse_lit", o_bus_err, 32'd0);

    // misaligned half/word
`ifdef MISALIGN_TRAP_EN
    drive(32'h140, 32'h6, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    cur.stall = 1'b0; nxt = zero_obs; nxt.mis = 1'b1;
    tick();
    chk("trap_misalign_lit", o_misalign, 32'd1);
    alu(32'h144, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("trap_pulse_lit", o_misalign, 32'd0);
`else
    access(32'h140, 32'h6, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 0, 32'hDEAD_BEEF);
    chk("lw_forced_addr_lit", snap_addr, 32'h4);
    chk("lw_forced_be_lit", snap_be, 32'b1111);
    access(32'h144, 32'h103, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 0, 32'h1234_5678);
    chk("lh_forced_lit", o_readData, 32'h0000_1234);
`endif

    // reset in the 2nd BUSY cycle, late ack afterwards must be ignored
    drive(32'h148, 32'h40, 32'h0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    cur.stall = 1'b1;
    nxt = zero_obs; nxt.req = 1'b1; nxt.addr = 32'h40; nxt.be = 4'b1111;
    tick();
    cur.stall = 1'b1;
    tick();
    rst = 1'b1;
    cur.stall = 1'b0; nxt = zero_obs;
    tick();
    rst = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h5555_5555;
    cur.stall = 1'b0; nxt = zero_obs;
    tick();
    i_dmem_ack = 1'b0;
    chk("rst_busy_req_lit", o_dmem_req, 32'd0);
    chk("rst_busy_rw_lit", o_regWrite, 32'd0);
    chk("rst_busy_rdata_lit", o_readData, 32'd0);
    alu(32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
